mmio_arbiter: RTL and testbench

- Shares the CPU's single MMIO peripheral bus between two requesters.
  - Port 0: core data path, via the memory crossbar MMIO window.
  - Port 1: secondary master, e.g. the debug/UART loader.
- Round-robin arbitration, one transaction in flight at a time.
- Writes complete in the grant cycle. Reads wait a fixed, parameterised peripheral latency and return data on a per-requester valid strobe.

---
 rtl/mmio_arbiter.sv | 159 +++++++++++++++
 tb/tb_mmio_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_arbiter.sv
// Two-requester round-robin arbiter for the single MMIO peripheral bus; one transaction in flight.
// Optional lock-based grant extension is enabled with `define MMIO_ARB_LOCK_EN.
module mmio_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req0,
  input  logic [29:0] i_addr0,
  input  logic [31:0] i_data0,
  input  logic [3:0]  i_mask0,
  input  logic        i_wren0,
  input  logic        i_lock0,
  output logic        o_gnt0,
  output logic        o_rvalid0,
  output logic [31:0] o_rdata0,
  input  logic        i_req1,
  input  logic [29:0] i_addr1,
  input  logic [31:0] i_data1,
  input  logic [3:0]  i_mask1,
  input  logic        i_wren1,
  input  logic        i_lock1,
  output logic        o_gnt1,
  output logic        o_rvalid1,
  output logic [31:0] o_rdata1,
  output logic [29:0] o_mmio_addr,
  output logic [31:0] o_mmio_data,
  output logic [3:0]  o_mmio_mask,
  output logic        o_mmio_wren,
  input  logic [31:0] i_mmio_data
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4 || MAX_LOCK < 2) begin : g_bad_param
    $error("mmio_arbiter: RD_LATENCY must be 1..4 and MAX_LOCK at least 2");
  end

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t      state_q, state_d;
  logic        rr_last_q, rr_last_d;
  logic [1:0]  rd_cnt_q, rd_cnt_d;
  logic        rd_owner_q, rd_owner_d;
  logic [29:0] rd_addr_q, rd_addr_d;
  logic        win;
  logic        win_wren;

`ifdef MMIO_ARB_LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK) + 1;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           lock_hit;
`else
  logic unused_lock;
  assign unused_lock = i_lock0 ^ i_lock1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      rd_cnt_q   <= '0;
      rd_owner_q <= 1'b0;
      rd_addr_q  <= '0;
`ifdef MMIO_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_owner_q <= rd_owner_d;
      rd_addr_q  <= rd_addr_d;
`ifdef MMIO_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    rd_cnt_d    = rd_cnt_q;
    rd_owner_d  = rd_owner_q;
    rd_addr_d   = rd_addr_q;
    win         = 1'b0;
    win_wren    = 1'b0;
    o_gnt0      = 1'b0;
    o_gnt1      = 1'b0;
    o_rvalid0   = 1'b0;
    o_rvalid1   = 1'b0;
    o_rdata0    = '0;
    o_rdata1    = '0;
    o_mmio_addr = '0;
    o_mmio_data = '0;
    o_mmio_mask = '0;
    o_mmio_wren = 1'b0;
`ifdef MMIO_ARB_LOCK_EN
    lock_cnt_d  = lock_cnt_q;
    lock_hit    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (i_req0 || i_req1) begin
          win = (i_req0 && i_req1) ? ~rr_last_q : i_req1;
`ifdef MMIO_ARB_LOCK_EN
          // The previous winner may keep the bus while locking, up to MAX_LOCK grants in a row.
          lock_hit = (rr_last_q ? (i_req1 && i_lock1) : (i_req0 && i_lock0)) &&
                     (lock_cnt_q < LCW'(MAX_LOCK - 1));
          if (lock_hit) win = rr_last_q;
          lock_cnt_d = lock_hit ? lock_cnt_q + 1'b1 : '0;
`endif
          win_wren    = win ? i_wren1 : i_wren0;
          o_gnt0      = ~win;
          o_gnt1      = win;
          o_mmio_addr = win ? i_addr1 : i_addr0;
          o_mmio_data = win ? i_data1 : i_data0;
          o_mmio_mask = win ? i_mask1 : i_mask0;
          o_mmio_wren = win_wren;
          rr_last_d   = win;
          if (!win_wren) begin
            rd_addr_d  = win ? i_addr1 : i_addr0;
            rd_owner_d = win;
            rd_cnt_d   = 2'(RD_LATENCY - 1);
            state_d    = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        o_mmio_addr = rd_addr_q;
        if (rd_cnt_q == 2'd0) begin
          o_rvalid0 = ~rd_owner_q;
          o_rvalid1 = rd_owner_q;
          o_rdata0  = rd_owner_q ? 32'd0 : i_mmio_data;
          o_rdata1  = rd_owner_q ? i_mmio_data : 32'd0;
          state_d   = IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus is silent while reset is held, even though the outputs are combinational.
    if (!rst_n) begin
      o_gnt0      = 1'b0;
      o_gnt1      = 1'b0;
      o_rvalid0   = 1'b0;
      o_rvalid1   = 1'b0;
      o_rdata0    = '0;
      o_rdata1    = '0;
      o_mmio_addr = '0;
      o_mmio_data = '0;
      o_mmio_mask = '0;
      o_mmio_wren = 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: grant order, bus payload, read return via a scoreboard queue.
module tb_mmio_arbiter;
  localparam int RD_LAT = 2;
  localparam int MAXL   = 8;
  localparam logic [31:0] K = 32'h12345658;

  logic        clk, rst_n;
  logic        i_req0, i_wren0, i_lock0, o_gnt0, o_rvalid0;
  logic [29:0] i_addr0;
  logic [31:0] i_data0, o_rdata0;
  logic [3:0]  i_mask0;
  logic        i_req1, i_wren1, i_lock1, o_gnt1, o_rvalid1;
  logic [29:0] i_addr1;
  logic [31:0] i_data1, o_rdata1;
  logic [3:0]  i_mask1;
  logic [29:0] o_mmio_addr;
  logic [31:0] o_mmio_data;
  logic [3:0]  o_mmio_mask;
  logic        o_mmio_wren;
  logic [31:0] i_mmio_data;

  mmio_arbiter #(.RD_LATENCY(RD_LAT), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0(i_req0), .i_addr0(i_addr0), .i_data0(i_data0), .i_mask0(i_mask0),
    .i_wren0(i_wren0), .i_lock0(i_lock0), .o_gnt0(o_gnt0), .o_rvalid0(o_rvalid0),
    .o_rdata0(o_rdata0),
    .i_req1(i_req1), .i_addr1(i_addr1), .i_data1(i_data1), .i_mask1(i_mask1),
    .i_wren1(i_wren1), .i_lock1(i_lock1), .o_gnt1(o_gnt1), .o_rvalid1(o_rvalid1),
    .o_rdata1(o_rdata1),
    .o_mmio_addr(o_mmio_addr), .o_mmio_data(o_mmio_data), .o_mmio_mask(o_mmio_mask),
    .o_mmio_wren(o_mmio_wren), .i_mmio_data(i_mmio_data)
  );

  // Peripheral model: read data is a fixed function of the presented address.
  assign i_mmio_data = {2'b00, o_mmio_addr} ^ K;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle, then retire any read return against the scoreboard.
  task automatic mon();
    rd_exp_t e;
    #2;
    if (o_rvalid0 || o_rvalid1) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", 32'({o_rvalid1, o_rvalid0}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rv_owner", 32'(o_rvalid1), 32'(e.owner));
        chk("rv_data", o_rvalid1 ? o_rdata1 : o_rdata0, e.data);
      end
    end
    chk("rv_both", 32'(o_rvalid0 & o_rvalid1), 32'd0);
    chk("rdata0_quiet", o_rvalid0 ? 32'd0 : o_rdata0, 32'd0);
    chk("rdata1_quiet", o_rvalid1 ? 32'd0 : o_rdata1, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic w, input logic l);
    i_req0 = r; i_addr0 = a; i_data0 = d; i_mask0 = m; i_wren0 = w; i_lock0 = l;
  endtask

  task automatic set1(input logic r, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic w, input logic l);
    i_req1 = r; i_addr1 = a; i_data1 = d; i_mask1 = m; i_wren1 = w; i_lock1 = l;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic e1;
    rst_n = 1'b0;
    set0(0, '0, '0, '0, 0, 0);
    set1(0, '0, '0, '0, 0, 0);
    tick();

    // Reset: requests during reset are not granted, bus forced to 0.
    set0(1, 30'h11, 32'h1111, 4'hF, 1, 0);
    set1(1, 30'h22, 32'h2222, 4'hF, 1, 0);
    mon();
    chk("rst_gnt0", 32'(o_gnt0), 0);
    chk("rst_gnt1", 32'(o_gnt1), 0);
    chk("rst_addr", 32'(o_mmio_addr), 0);
    chk("rst_data", o_mmio_data, 0);
    chk("rst_mask", 32'(o_mmio_mask), 0);
    chk("rst_wren", 32'(o_mmio_wren), 0);
    tick();
    rst_n = 1'b1;
    set1(0, '0, '0, '0, 0, 0);

    // Single write from requester 0.
    set0(1, 30'h10, 32'hDEADBEEF, 4'hF, 1, 0);
    mon();
    chk("w0_gnt0", 32'(o_gnt0), 1);
    chk("w0_gnt1", 32'(o_gnt1), 0);
    chk("w0_wren", 32'(o_mmio_wren), 1);
    chk("w0_addr", 32'(o_mmio_addr), 32'h10);
    chk("w0_data", o_mmio_data, 32'hDEADBEEF);
    chk("w0_mask", 32'(o_mmio_mask), 32'hF);
    tick();
    set0(0, '0, '0, '0, 0, 0);
    mon();
    chk("w0_after_wren", 32'(o_mmio_wren), 0);
    chk("w0_after_addr", 32'(o_mmio_addr), 0);
    chk("w0_after_gnt0", 32'(o_gnt0), 0);
    tick();

    // Both write continuously after reset: strict alternation starting at 0.
    rst_pulse();
    set0(1, 30'h100, 32'h1000, 4'hF, 1, 0);
    set1(1, 30'h200, 32'h2000, 4'hF, 1, 0);
    for (int i = 0; i < 6; i++) begin
      e1 = 1'(i % 2);
      mon();
      chk($sformatf("alt%0d_gnt0", i), 32'(o_gnt0), 32'(!e1));
      chk($sformatf("alt%0d_gnt1", i), 32'(o_gnt1), 32'(e1));
      chk($sformatf("alt%0d_addr", i), 32'(o_mmio_addr), e1 ? 32'h200 : 32'h100);
      tick();
    end
    set0(0, '0, '0, '0, 0, 0);
    set1(0, '0, '0, '0, 0, 0);

    // Read from requester 1 while requester 0 queues a write behind it.
    set1(1, 30'h20, 32'h0, 4'h0, 0, 0);
    sb.push_back('{owner: 1'b1, data: 32'h12345678});
    mon();
    chk("rd_gnt1", 32'(o_gnt1), 1);
    chk("rd_addr", 32'(o_mmio_addr), 32'h20);
    chk("rd_wren", 32'(o_mmio_wren), 0);
    tick();
    set1(0, '0, '0, '0, 0, 0);
    set0(1, 30'h30, 32'hCAFEF00D, 4'hF, 1, 0);
    for (int k = 1; k <= RD_LAT; k++) begin
      mon();
      chk($sformatf("rdw%0d_gnt0", k), 32'(o_gnt0), 0);
      chk($sformatf("rdw%0d_addr", k), 32'(o_mmio_addr), 32'h20);
      chk($sformatf("rdw%0d_wren", k), 32'(o_mmio_wren), 0);
      chk($sformatf("rdw%0d_data", k), o_mmio_data, 0);
      chk($sformatf("rdw%0d_rvalid1", k), 32'(o_rvalid1), 32'(k == RD_LAT));
      tick();
    end
    mon();
    chk("post_rd_gnt0", 32'(o_gnt0), 1);
    chk("post_rd_addr", 32'(o_mmio_addr), 32'h30);
    chk("post_rd_data", o_mmio_data, 32'hCAFEF00D);
    tick();
    set0(0, '0, '0, '0, 0, 0);
    chk("rd_sb_drained", 32'(sb.size()), 0);

    // Reset mid-read: no return ever, then requester 0 has priority.
    set0(1, 30'h40, 32'h0, 4'h0, 0, 0);
    mon();
    chk("rr_gnt0", 32'(o_gnt0), 1);
    chk("rr_addr", 32'(o_mmio_addr), 32'h40);
    tick();
    set0(0, '0, '0, '0, 0, 0);
    rst_n = 1'b0;
    mon();
    chk("rr_rst_rvalid0", 32'(o_rvalid0), 0);
    chk("rr_rst_addr", 32'(o_mmio_addr), 0);
    tick();
    rst_n = 1'b1;
    set0(1, 30'h50, 32'h5, 4'hF, 1, 0);
    set1(1, 30'h60, 32'h6, 4'hF, 1, 0);
    mon();
    chk("rr_first_gnt0", 32'(o_gnt0), 1);
    chk("rr_first_gnt1", 32'(o_gnt1), 0);
    tick();
    mon();
    chk("rr_second_gnt1", 32'(o_gnt1), 1);
    tick();
    set0(0, '0, '0, '0, 0, 0);
    set1(0, '0, '0, '0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      mon();
      chk("rr_no_rvalid0", 32'(o_rvalid0), 0);
      tick();
    end

    // Requester 0 holds lock while both write continuously.
    rst_pulse();
    set0(1, 30'h70, 32'h7, 4'hF, 1, 1);
    set1(1, 30'h80, 32'h8, 4'hF, 1, 0);
    for (int i = 0; i < 12; i++) begin
`ifdef MMIO_ARB_LOCK_EN
      e1 = (i == MAXL);
`else
      e1 = 1'(i % 2);
`endif
      mon();
      chk($sformatf("lock%0d_gnt0", i), 32'(o_gnt0), 32'(!e1));
      chk($sformatf("lock%0d_gnt1", i), 32'(o_gnt1), 32'(e1));
      tick();
    end
    set0(0, '0, '0, '0, 0, 0);
    set1(0, '0, '0, '0, 0, 0);

    // Partial byte mask write from requester 1.
    set1(1, 30'h90, 32'hA5A55A5A, 4'b0101, 1, 0);
    mon();
    chk("mask_gnt1", 32'(o_gnt1), 1);
    chk("mask_gnt0", 32'(o_gnt0), 0);
    chk("mask_mask", 32'(o_mmio_mask), 32'h5);
    chk("mask_data", o_mmio_data, 32'hA5A55A5A);
    chk("mask_addr", 32'(o_mmio_addr), 32'h90);
    chk("mask_wren", 32'(o_mmio_wren), 1);
    tick();
    set1(0, '0, '0, '0, 0, 0);
    mon();
    tick();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
